// File: rtl/axil_master.sv
// AXI4-Lite master with one transaction outstanding: 3-cycle minimum cmd-to-rsp latency.
// cmd_ready only while idle; rsp is held until rsp_ready; optional timeout answers SLVERR.
module axil_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, WR_AW, WR_B, RD_A, RD_R, RSP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  resp_q, resp_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy;
  logic        timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;

    busy    = (state_q == WR_AW) || (state_q == WR_B) || (state_q == RD_A) || (state_q == RD_R);
    cnt_d   = busy ? cnt_q + 16'd1 : cnt_q;
    timeout = busy && (TO_LIMIT != 16'd0) && (cnt_d == TO_LIMIT);

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cnt_d  = '0;
          addr_d = cmd_addr & 32'hFFFF_FFFC;
          if (cmd_write) begin
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_AW;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_A;
          end
        end
      end
      WR_AW: begin
        awvalid_d = awvalid_q & ~M_AXI_AWREADY;
        wvalid_d  = wvalid_q & ~M_AXI_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_B;
        end
      end
      WR_B: begin
        if (M_AXI_BVALID) begin
          bready_d    = 1'b0;
          rdata_d     = '0;
          resp_d      = M_AXI_BRESP;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_A: begin
        arvalid_d = arvalid_q & ~M_AXI_ARREADY;
        if (!arvalid_d) begin
          rready_d = 1'b1;
          state_d  = RD_R;
        end
      end
      RD_R: begin
        if (M_AXI_RVALID) begin
          rready_d    = 1'b0;
          rdata_d     = M_AXI_RDATA;
          resp_d      = M_AXI_RRESP;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A response captured in the expiry cycle already steered us to RSP and wins.
    if (timeout && (state_d != RSP)) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rdata_d     = '0;
      resp_d      = 2'b10;
      rsp_valid_d = 1'b1;
      state_d     = RSP;
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: doc/axil_master.md
AXIL_MASTER -- requirements
Module: axil_master
Interface
REQ-001 Parameter: TIMEOUT, 255, cycles allowed from command accept to response capture; 0 disables the timeout.
REQ-002 clk  in  1  single clock for all logic; the AXI-Lite side is synchronous to it.
REQ-003 rst  in  1  reset, asynchronous assert, active-high.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-006 cmd_write  in  1  1 = write transaction, 0 = read transaction.
REQ-007 cmd_addr  in  32  byte address.
REQ-008 cmd_wdata  in  32  write data.
REQ-009 cmd_wstrb  in  4  write byte strobes.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  response consumed when high together with rsp_valid.
REQ-012 rsp_rdata  out  32  read data; 0 for writes and timeouts.
REQ-013 rsp_resp  out  2  captured BRESP/RRESP; 2'b10 on timeout.
REQ-014 M_AXI_AWADDR  out  32  write address.
REQ-015 M_AXI_AWVALID  out  1  write address valid.
REQ-016 M_AXI_AWREADY  in  1  write address ready.
REQ-017 M_AXI_WDATA  out  32  write data.
REQ-018 M_AXI_WSTRB  out  4  write strobes.
REQ-019 M_AXI_WVALID  out  1  write data valid.
REQ-020 M_AXI_WREADY  in  1  write data ready.
REQ-021 M_AXI_BRESP  in  2  write response code.
REQ-022 M_AXI_BVALID  in  1  write response valid.
REQ-023 M_AXI_BREADY  out  1  write response ready.
REQ-024 M_AXI_ARADDR  out  32  read address.
REQ-025 M_AXI_ARVALID  out  1  read address valid.
REQ-026 M_AXI_ARREADY  in  1  read address ready.
REQ-027 M_AXI_RDATA  in  32  read data.
REQ-028 M_AXI_RRESP  in  2  read response code.
REQ-029 M_AXI_RVALID  in  1  read data valid.
REQ-030 M_AXI_RREADY  out  1  read data ready.
Function
REQ-031 Registered-output FSM with states IDLE, WR_AW (AW and W in flight), WR_B, RD_A, RD_R, RSP; cmd_ready SHALL be 1 only in IDLE, so there is one outstanding transaction at most.
REQ-032 IDLE, cmd_valid at cycle N: fields captured with AWADDR/ARADDR[1:0] forced to 2'b00; next state WR_AW (AWVALID=WVALID=1 at N+1) or RD_A (ARVALID=1 at N+1).
REQ-033 WR_AW: AWVALID and WVALID SHALL each drop the cycle after their own handshake and be independent of each other; after both handshakes (same cycle or either order) go to WR_B with BREADY=1.
REQ-034 WR_B: on BVALID&BREADY capture BRESP, BREADY drops, go to RSP; minimum write latency with slave readies held high is cmd accept N -> rsp_valid N+3.
REQ-035 RD_A: on ARVALID&ARREADY go to RD_R with RREADY=1; on RVALID&RREADY capture RDATA/RRESP, go to RSP; minimum read latency is N -> rsp_valid N+3.
REQ-036 VALID outputs SHALL NOT drop before handshake except on timeout or reset; all AXI payload outputs hold stable while their VALID is high.
REQ-037 RSP: rsp_valid=1 and rsp_rdata/rsp_resp held stable until rsp_ready; return to IDLE on the next cycle, with cmd_ready=1 then.
REQ-038 Timeout: a 16-bit counter is cleared on command accept and increments every non-IDLE, non-RSP cycle; when it equals TIMEOUT (TIMEOUT!=0), all AXI VALID/READY drop, rsp_resp=2'b10, rsp_rdata=0, go to RSP.
REQ-039 A BVALID or RVALID arriving in IDLE or RSP is ignored (BREADY/RREADY are low then); a response arriving in the same cycle as the timeout wins over the timeout.
Reset
REQ-040 On rst all VALID/READY outputs, rsp_rdata, rsp_resp, AXI address/data outputs and the counter SHALL be 0 immediately and the state SHALL be IDLE; an in-flight transaction is discarded without a response.
Verification
REQ-041 Write 0x10 <- 0x0000_0003, strb 0xF, readies high, BRESP=00 -> AW/W at N+1, rsp_valid at N+3 with rsp_resp=00 and rsp_rdata=0.
REQ-042 Write with WREADY 3 cycles after AWREADY -> AWVALID is low after its handshake and BREADY asserts only after the W handshake.
REQ-043 Read addr 0x13, slave returns RDATA=0xDEADBEEF, RRESP=00 -> ARADDR=0x10, rsp_rdata=0xDEADBEEF, held until rsp_ready.
REQ-044 TIMEOUT=8, AWREADY never asserted -> at cycle 8 after accept all VALIDs drop and the response is 2'b10; a later BVALID is ignored.
REQ-045 rst asserted while in RD_R -> ARVALID/RREADY/rsp_valid read 0 in that cycle; the next command completes normally.
